pci_target_addr_decoder: RTL and testbench

- Registered PCI target address decoder and DEVSEL# generator for the PCI slave.
- Detects the address phase and latches AD and C/BE#.
- Matches the latched address against NUM_BARS base/size windows, filtered by an enabled-command mask.
- Asserts devsel_n with programmable fast/medium/slow timing, holds it through the burst, and tracks the current burst address for the slave datapath.

---
 rtl/pci_pkg.sv | 39 +++
 rtl/pci_bar_match.sv | 21 ++
 rtl/pci_target_addr_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_pci_target_addr_decoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// -----------------------------------------------------------------------------
// pci_pkg
// Shared definitions for the PCI target address decoder: bus command codes,
// decoder state encoding, DEVSEL# timing selectors and small helper functions
// used both for decoding and for elaboration-time parameter checks.
// -----------------------------------------------------------------------------
package pci_pkg;

    // C/BE# bus command codes (already inverted to active-high form)
    localparam logic [3:0] CMD_IO_READ   = 4'h2;
    localparam logic [3:0] CMD_IO_WRITE  = 4'h3;
    localparam logic [3:0] MEM_READ      = 4'h6;
    localparam logic [3:0] MEM_WRITE     = 4'h7;
    localparam logic [3:0] CFG_READ      = 4'hA;
    localparam logic [3:0] CFG_WRITE     = 4'hB;

    // DEVSEL# response timing selectors
    localparam int DEVSEL_FAST   = 0;
    localparam int DEVSEL_MEDIUM = 1;
    localparam int DEVSEL_SLOW   = 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DECODE     = 2'd1,
        CLAIMED    = 2'd2,
        TURNAROUND = 2'd3
    } pci_state_e;

    // True when the command code is enabled in the claim mask
    function automatic logic cmd_enabled(input logic [15:0] mask, input logic [3:0] cmd);
        return mask[cmd];
    endfunction

    // True when a base address has no bits set below its window size
    function automatic logic base_aligned(input logic [31:0] base, input logic [5:0] size_log2);
        return (base & ((32'd1 << size_log2) - 32'd1)) == 32'd0;
    endfunction

endpackage

// File: rtl/pci_bar_match.sv
// -----------------------------------------------------------------------------
// pci_bar_match
// Combinational single-window comparator. Reports a hit when the address falls
// inside the naturally aligned window [base, base + 2^size_log2 - 1].
// Ports:
//   i_base       - window base address (aligned to the window size)
//   i_size_log2  - log2 of the window size in bytes
//   i_addr       - address under test
//   o_hit        - address lies inside the window
// -----------------------------------------------------------------------------
module pci_bar_match (
    input  logic [31:0] i_base,
    input  logic [5:0]  i_size_log2,
    input  logic [31:0] i_addr,
    output logic        o_hit
);

    // Comparing only the bits above the window size makes both bounds inclusive
    assign o_hit = (i_addr >> i_size_log2) == (i_base >> i_size_log2);

endmodule

// File: rtl/pci_target_addr_decoder.sv
// -----------------------------------------------------------------------------
// pci_target_addr_decoder
// Registered PCI target address decoder and DEVSEL# generator. Latches the
// address/command on the address phase, matches the address against NUM_BARS
// windows (lowest index wins), claims the transaction with programmable
// fast/medium/slow DEVSEL# timing and tracks the burst address.
// Ports:
//   i_clk       - PCI clock, rising edge
//   i_rst_n     - asynchronous active-low reset
//   i_frame_n   - FRAME#
//   i_irdy_n    - IRDY#
//   i_trdy_n    - TRDY# as driven by the slave datapath (sampled only)
//   i_ad        - AD bus
//   i_cbe_n     - C/BE# bus
//   o_devsel_n  - DEVSEL#, active low
//   o_bar_hit   - one-hot selected window, valid while claimed
//   o_cmd       - latched bus command
//   o_cur_addr  - current data-phase address
//   o_claimed   - this target owns the transaction
// -----------------------------------------------------------------------------
module pci_target_addr_decoder
    import pci_pkg::*;
#(
    parameter int                      NUM_BARS      = 2,
    parameter logic [NUM_BARS*32-1:0]  BAR_BASES     = {32'h0000_2000, 32'h0000_0010},
    parameter logic [NUM_BARS*6-1:0]   BAR_SIZE_LOG2 = {6'd12, 6'd4},
    parameter logic [15:0]             CMD_MASK      = 16'h00C0,
    parameter int                      DEVSEL_SPEED  = DEVSEL_FAST
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_frame_n,
    input  logic                i_irdy_n,
    input  logic                i_trdy_n,
    input  logic [31:0]         i_ad,
    input  logic [3:0]          i_cbe_n,
    output logic                o_devsel_n,
    output logic [NUM_BARS-1:0] o_bar_hit,
    output logic [3:0]          o_cmd,
    output logic [31:0]         o_cur_addr,
    output logic                o_claimed
);

    // ---------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ---------------------------------------------------------------------
    if (NUM_BARS < 1 || NUM_BARS > 8) begin : g_bad_num_bars
        $error("pci_target_addr_decoder: NUM_BARS must be 1..8");
    end
    if (DEVSEL_SPEED < 0 || DEVSEL_SPEED > 2) begin : g_bad_speed
        $error("pci_target_addr_decoder: DEVSEL_SPEED must be 0..2");
    end
    for (genvar g = 0; g < NUM_BARS; g++) begin : g_chk_base
        if (!base_aligned(BAR_BASES[32*g +: 32], BAR_SIZE_LOG2[6*g +: 6])) begin : g_bad_base
            $error("pci_target_addr_decoder: BAR base not aligned to its size");
        end
    end

    localparam logic [1:0] WAIT_INIT = 2'(DEVSEL_SPEED);

    pci_state_e          r_state;
    logic [1:0]          r_wait;
    logic                r_frame_prev;
    logic                r_devsel_n;
    logic [NUM_BARS-1:0] r_bar_hit;
    logic [3:0]          r_cmd;
    logic [31:0]         r_cur_addr;
    logic                r_claimed;

    pci_state_e          w_state_nxt;
    logic [1:0]          w_wait_nxt;
    logic                w_devsel_nxt;
    logic [NUM_BARS-1:0] w_bar_hit_nxt;
    logic [3:0]          w_cmd_nxt;
    logic [31:0]         w_addr_nxt;
    logic                w_claimed_nxt;

    logic [NUM_BARS-1:0] w_win_hit;
    logic [NUM_BARS-1:0] w_hit_raw;
    logic [NUM_BARS-1:0] w_hit_sel;
    logic                w_found;
    logic                w_cmd_ok;
    logic                w_addr_phase;
    logic                w_abort;
    logic                w_complete;

    // One comparator per decode window, evaluated on the latched address
    for (genvar b = 0; b < NUM_BARS; b++) begin : g_bar
        pci_bar_match u_match (
            .i_base      (BAR_BASES[32*b +: 32]),
            .i_size_log2 (BAR_SIZE_LOG2[6*b +: 6]),
            .i_addr      (r_cur_addr),
            .o_hit       (w_win_hit[b])
        );
    end

    assign w_cmd_ok     = cmd_enabled(CMD_MASK, r_cmd);
    assign w_hit_raw    = w_win_hit & {NUM_BARS{w_cmd_ok}};
    // Falling FRAME# edge; the previous-sample term stops a back-to-back
    // transaction that began during turnaround from being seen as new
    assign w_addr_phase = !i_frame_n && r_frame_prev;
    assign w_abort      = i_frame_n && i_irdy_n;
    assign w_complete   = !i_irdy_n && !i_trdy_n;

    // Priority encoder: lowest-index window wins so bar_hit stays one-hot
    always_comb begin
        w_hit_sel = '0;
        w_found   = 1'b0;
        for (int i = 0; i < NUM_BARS; i++) begin
            if (!w_found) begin
                w_hit_sel[i] = w_hit_raw[i];
                w_found      = w_hit_raw[i];
            end else begin
                w_hit_sel[i] = 1'b0;
            end
        end
    end

    // Next-state and next-output logic for the decode FSM
    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait;
        w_devsel_nxt  = r_devsel_n;
        w_bar_hit_nxt = r_bar_hit;
        w_cmd_nxt     = r_cmd;
        w_addr_nxt    = r_cur_addr;
        w_claimed_nxt = r_claimed;

        case (r_state)
            IDLE: begin
                if (w_addr_phase) begin
                    w_state_nxt = DECODE;
                    w_wait_nxt  = WAIT_INIT;
                    w_addr_nxt  = i_ad;
                    w_cmd_nxt   = ~i_cbe_n;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DECODE: begin
                if (w_abort) begin
                    w_state_nxt   = IDLE;
                    w_devsel_nxt  = 1'b1;
                    w_claimed_nxt = 1'b0;
                    w_bar_hit_nxt = '0;
                end else if (!w_found) begin
                    w_state_nxt   = IDLE;
                end else if (r_wait == 2'd0) begin
                    w_state_nxt   = CLAIMED;
                    w_devsel_nxt  = 1'b0;
                    w_claimed_nxt = 1'b1;
                    w_bar_hit_nxt = w_hit_sel;
                end else begin
                    w_wait_nxt    = r_wait - 2'd1;
                end
            end
            CLAIMED: begin
                if (w_abort) begin
                    w_state_nxt   = IDLE;
                    w_devsel_nxt  = 1'b1;
                    w_claimed_nxt = 1'b0;
                    w_bar_hit_nxt = '0;
                end else if (w_complete) begin
                    w_addr_nxt = r_cur_addr + 32'd4;
                    if (i_frame_n) begin
                        w_state_nxt   = TURNAROUND;
                        w_devsel_nxt  = 1'b1;
                        w_claimed_nxt = 1'b0;
                        w_bar_hit_nxt = '0;
                    end else begin
                        w_state_nxt   = CLAIMED;
                    end
                end else begin
                    w_state_nxt = CLAIMED;
                end
            end
            TURNAROUND: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt   = IDLE;
                w_devsel_nxt  = 1'b1;
                w_claimed_nxt = 1'b0;
                w_bar_hit_nxt = '0;
            end
        endcase
    end

    // State and registered-output update
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_wait       <= 2'd0;
            r_frame_prev <= 1'b1;
            r_devsel_n   <= 1'b1;
            r_bar_hit    <= '0;
            r_cmd        <= 4'd0;
            r_cur_addr   <= 32'd0;
            r_claimed    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait       <= w_wait_nxt;
            r_frame_prev <= i_frame_n;
            r_devsel_n   <= w_devsel_nxt;
            r_bar_hit    <= w_bar_hit_nxt;
            r_cmd        <= w_cmd_nxt;
            r_cur_addr   <= w_addr_nxt;
            r_claimed    <= w_claimed_nxt;
        end
    end

    assign o_devsel_n = r_devsel_n;
    assign o_bar_hit  = r_bar_hit;
    assign o_cmd      = r_cmd;
    assign o_cur_addr = r_cur_addr;
    assign o_claimed  = r_claimed;

endmodule

// File: tb/tb_pci_target_addr_decoder.sv
// -----------------------------------------------------------------------------
// tb_pci_target_addr_decoder
// Directed bench: three decoders (fast/medium/slow DEVSEL#) share one bus.
// -----------------------------------------------------------------------------
module tb_pci_target_addr_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_n = 1'b1;
    logic        irdy_n = 1'b1;
    logic        trdy_n = 1'b1;
    logic [31:0] ad = 32'd0;
    logic [3:0]  cbe_n = 4'hF;

    logic        devsel0, devsel1, devsel2;
    logic [1:0]  hit0, hit1, hit2;
    logic [3:0]  cmd0, cmd1, cmd2;
    logic [31:0] addr0, addr1, addr2;
    logic        clm0, clm1, clm2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pci_target_addr_decoder #(.DEVSEL_SPEED(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_n(frame_n), .i_irdy_n(irdy_n),
        .i_trdy_n(trdy_n), .i_ad(ad), .i_cbe_n(cbe_n), .o_devsel_n(devsel0),
        .o_bar_hit(hit0), .o_cmd(cmd0), .o_cur_addr(addr0), .o_claimed(clm0));

    pci_target_addr_decoder #(.DEVSEL_SPEED(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_n(frame_n), .i_irdy_n(irdy_n),
        .i_trdy_n(trdy_n), .i_ad(ad), .i_cbe_n(cbe_n), .o_devsel_n(devsel1),
        .o_bar_hit(hit1), .o_cmd(cmd1), .o_cur_addr(addr1), .o_claimed(clm1));

    pci_target_addr_decoder #(.DEVSEL_SPEED(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_n(frame_n), .i_irdy_n(irdy_n),
        .i_trdy_n(trdy_n), .i_ad(ad), .i_cbe_n(cbe_n), .o_devsel_n(devsel2),
        .o_bar_hit(hit2), .o_cmd(cmd2), .o_cur_addr(addr2), .o_claimed(clm2));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [3:0] c);
        frame_n = 1'b0;
        ad      = a;
        cbe_n   = ~c;
        cyc();
    endtask

    // Single-data-phase transaction; checks the fast decoder's claim result
    task automatic probe(input string tag, input logic [31:0] a, input logic [3:0] c,
                         input logic [1:0] exp_hit);
        addr_phase(a, c);
        frame_n = 1'b1; irdy_n = 1'b0; trdy_n = 1'b1; ad = 32'd0; cbe_n = 4'hF;
        cyc();
        check_val({tag, "_devsel"}, {31'd0, devsel0}, (exp_hit == 2'b00) ? 32'd1 : 32'd0);
        check_val({tag, "_hit"}, {30'd0, hit0}, {30'd0, exp_hit});
        cyc();
        cyc();
        trdy_n = 1'b0;
        cyc();
        check_val({tag, "_end"}, {31'd0, devsel0}, 32'd1);
        irdy_n = 1'b1; trdy_n = 1'b1;
        cyc();
        cyc();
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_devsel", {31'd0, devsel0}, 32'd1);
        check_val("rst_claimed", {31'd0, clm0}, 32'd0);
        check_val("rst_addr", addr0, 32'd0);
        check_val("rst_cmd", {28'd0, cmd0}, 32'd0);
        check_val("rst_hit", {30'd0, hit0}, 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Basic memory read at 0x15 with DEVSEL# timing of all three speeds
        addr_phase(32'h0000_0015, 4'h6);
        check_val("t1_cmd", {28'd0, cmd0}, 32'd6);
        check_val("t1_addr", addr0, 32'h15);
        check_val("t1_dev_e0", {31'd0, devsel0}, 32'd1);
        frame_n = 1'b1; irdy_n = 1'b0; trdy_n = 1'b1; ad = 32'd0; cbe_n = 4'hF;
        cyc();
        check_val("t4_fast_e1", {31'd0, devsel0}, 32'd0);
        check_val("t4_med_e1", {31'd0, devsel1}, 32'd1);
        check_val("t4_slow_e1", {31'd0, devsel2}, 32'd1);
        check_val("t1_hit", {30'd0, hit0}, 32'd1);
        check_val("t1_claimed", {31'd0, clm0}, 32'd1);
        cyc();
        check_val("t4_med_e2", {31'd0, devsel1}, 32'd0);
        check_val("t4_slow_e2", {31'd0, devsel2}, 32'd1);
        cyc();
        check_val("t4_slow_e3", {31'd0, devsel2}, 32'd0);
        check_val("t4_fast_hold", {31'd0, devsel0}, 32'd0);
        trdy_n = 1'b0;
        cyc();
        check_val("t1_rel_fast", {31'd0, devsel0}, 32'd1);
        check_val("t1_rel_slow", {31'd0, devsel2}, 32'd1);
        check_val("t1_rel_claimed", {31'd0, clm0}, 32'd0);
        check_val("t1_rel_hit", {30'd0, hit0}, 32'd0);
        check_val("t1_addr_inc", addr0, 32'h19);

        // Back-to-back address phase during turnaround is not claimed
        irdy_n = 1'b1; trdy_n = 1'b1;
        frame_n = 1'b0; ad = 32'h0000_0014; cbe_n = ~4'h7;
        cyc();
        cyc();
        check_val("b2b_cmd_hold", {28'd0, cmd0}, 32'd6);
        check_val("b2b_addr_hold", addr0, 32'h19);
        frame_n = 1'b1;
        cyc();
        cyc();
        check_val("b2b_devsel", {31'd0, devsel0}, 32'd1);
        check_val("b2b_claimed", {31'd0, clm0}, 32'd0);

        // Window boundaries
        probe("bnd_0f",   32'h0000_000F, 4'h6, 2'b00);
        probe("bnd_10",   32'h0000_0010, 4'h6, 2'b01);
        probe("bnd_1f",   32'h0000_001F, 4'h6, 2'b01);
        probe("bnd_20",   32'h0000_0020, 4'h6, 2'b00);
        probe("bnd_2fff", 32'h0000_2FFF, 4'h7, 2'b10);
        probe("bnd_3000", 32'h0000_3000, 4'h6, 2'b00);

        // Command filter: I/O read into a valid window
        probe("cmdfilt", 32'h0000_2000, 4'h2, 2'b00);
        check_val("cmdfilt_cmd", {28'd0, cmd0}, 32'd2);
        check_val("cmdfilt_claimed", {31'd0, clm0}, 32'd0);

        // Burst write, wait state on phase 2
        addr_phase(32'h0000_2000, 4'h7);
        frame_n = 1'b0; irdy_n = 1'b0; trdy_n = 1'b1;
        cyc();
        check_val("bur_dev", {31'd0, devsel0}, 32'd0);
        check_val("bur_hit", {30'd0, hit0}, 32'd2);
        check_val("bur_a0", addr0, 32'h2000);
        trdy_n = 1'b0;
        cyc();
        check_val("bur_a1", addr0, 32'h2004);
        trdy_n = 1'b1;
        cyc();
        check_val("bur_wait", addr0, 32'h2004);
        check_val("bur_wait_dev", {31'd0, devsel0}, 32'd0);
        trdy_n = 1'b0;
        cyc();
        check_val("bur_a2", addr0, 32'h2008);
        cyc();
        check_val("bur_a3", addr0, 32'h200C);
        frame_n = 1'b1;
        cyc();
        check_val("bur_end_dev", {31'd0, devsel0}, 32'd1);
        check_val("bur_end_addr", addr0, 32'h2010);
        irdy_n = 1'b1; trdy_n = 1'b1;
        cyc();
        cyc();

        // Master abort during DECODE
        addr_phase(32'h0000_0010, 4'h6);
        frame_n = 1'b1; irdy_n = 1'b1; trdy_n = 1'b1;
        cyc();
        check_val("abort_fast_dev", {31'd0, devsel0}, 32'd1);
        check_val("abort_fast_clm", {31'd0, clm0}, 32'd0);
        cyc();
        cyc();
        check_val("abort_slow_dev", {31'd0, devsel2}, 32'd1);
        check_val("abort_slow_clm", {31'd0, clm2}, 32'd0);
        cyc();

        // Asynchronous reset while claimed
        addr_phase(32'h0000_2000, 4'h7);
        frame_n = 1'b0; irdy_n = 1'b0; trdy_n = 1'b1;
        cyc();
        check_val("rstmid_pre", {31'd0, clm0}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rstmid_dev", {31'd0, devsel0}, 32'd1);
        check_val("rstmid_clm", {31'd0, clm0}, 32'd0);
        check_val("rstmid_addr", addr0, 32'd0);
        frame_n = 1'b1; irdy_n = 1'b1; trdy_n = 1'b1;
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();

        // Still decodes after reset
        probe("post_rst", 32'h0000_001F, 4'h6, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
